multi_in_accum: RTL and testbench

Parametrised blocking-port accumulator. It reads one value from each of NUM_IN blocking input channels in fixed round-robin order, sums them (wrapping or saturating), and delivers the sum on one blocking output port. It sits with the generated property-checked blocks and uses the same section-based control style and the same sync/notify port protocol.

---
 rtl/multi_in_accum_pkg.sv | 14 +
 rtl/multi_in_accum_add.sv | 26 ++
 rtl/multi_in_accum.sv | 117 +++++++++++
 tb/tb_multi_in_accum.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_in_accum_pkg.sv
// Shared types for the round-robin accumulator: section encoding and pointer sizing.
package multi_in_accum_types;

    typedef enum logic {
        SECTION_READ  = 1'b0,
        SECTION_WRITE = 1'b1
    } section_e;

    // Width of the channel pointer; never below one bit so a 2-channel block still has a pointer.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_in_accum_add.sv
// Signed adder used by the accumulator; wraps modulo 2^DATA_W or clamps at signed limits.
module multi_in_accum_add #(
    parameter int DATA_W   = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] sum_ext;

    assign sum_ext = {a[DATA_W-1], a} + {b[DATA_W-1], b};

    // Overflow shows up as the two top bits of the extended sum disagreeing.
    always_comb begin
        sum = sum_ext[DATA_W-1:0];
        if (SATURATE && (sum_ext[DATA_W] != sum_ext[DATA_W-1])) begin
            sum = sum_ext[DATA_W] ? S_MIN : S_MAX;
        end
    end

endmodule

// File: rtl/multi_in_accum.sv
// Reads one value per channel in fixed round-robin order, sums them, and hands the sum
// to a single consumer using sync/notify handshakes on every port.
module multi_in_accum
    import multi_in_accum_types::*;
#(
    parameter int NUM_IN   = 4,
    parameter int DATA_W   = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_sync,
    output logic [NUM_IN-1:0]        in_notify,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_sync,
    output logic                     out_notify
);

    localparam int PW = ptr_w(NUM_IN);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_IN - 1);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("multi_in_accum: NUM_IN must be in 2..16");
    end

    logic [DATA_W-1:0] chan [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
        assign chan[i] = in_data[i*DATA_W +: DATA_W];
    end

    section_e          section_q, nextsection;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_IN-1:0] in_notify_q, in_notify_d;
    logic              out_notify_q, out_notify_d;
    logic [DATA_W-1:0] add_sum;
    logic              rd_xfer;
    logic              wr_xfer;

    multi_in_accum_add #(
        .DATA_W   (DATA_W),
        .SATURATE (SATURATE)
    ) u_add (
        .a   (x_q),
        .b   (chan[ptr_q]),
        .sum (add_sum)
    );

    always_comb begin
        nextsection  = section_q;
        ptr_d        = ptr_q;
        x_d          = x_q;
        out_data_d   = out_data_q;
        in_notify_d  = in_notify_q;
        out_notify_d = out_notify_q;

        rd_xfer = (section_q == SECTION_READ) && in_notify_q[ptr_q] && in_sync[ptr_q];
        wr_xfer = (section_q == SECTION_WRITE) && out_notify_q && out_sync;

        case (section_q)
            SECTION_READ: begin
                if (rd_xfer) begin
                    x_d = add_sum;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d        = '0;
                        nextsection  = SECTION_WRITE;
                        in_notify_d  = '0;
                        out_notify_d = 1'b1;
                        out_data_d   = add_sum;
                    end else begin
                        ptr_d       = ptr_q + 1'b1;
                        // in_notify is one-hot at ptr, so advancing it is a plain shift.
                        in_notify_d = in_notify_q << 1;
                    end
                end
            end
            SECTION_WRITE: begin
                if (wr_xfer) begin
                    x_d          = '0;
                    nextsection  = SECTION_READ;
                    in_notify_d  = NUM_IN'(1);
                    out_notify_d = 1'b0;
                    out_data_d   = '0;
                end
            end
            default: begin
                nextsection = SECTION_READ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            section_q    <= SECTION_READ;
            ptr_q        <= '0;
            x_q          <= '0;
            out_data_q   <= '0;
            in_notify_q  <= NUM_IN'(1);
            out_notify_q <= 1'b0;
        end else begin
            section_q    <= nextsection;
            ptr_q        <= ptr_d;
            x_q          <= x_d;
            out_data_q   <= out_data_d;
            in_notify_q  <= in_notify_d;
            out_notify_q <= out_notify_d;
        end
    end

    assign in_notify  = in_notify_q;
    assign out_notify = out_notify_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_multi_in_accum.sv
// Self-checking bench: a 32-bit wrapping instance against a queue-based reference,
// plus a pair of 8-bit wrap/saturate instances driven in lockstep.
module tb_multi_in_accum;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic [127:0] d32;
    logic [3:0]   s32;
    logic         os32;
    logic [3:0]   n32;
    logic [31:0]  od32;
    logic         on32;

    logic [31:0]  d8;
    logic [3:0]   s8;
    logic         os8;
    logic [3:0]   nw8, ns8;
    logic [7:0]   odw8, ods8;
    logic         onw8, ons8;

    multi_in_accum #(.NUM_IN(4), .DATA_W(32), .SATURATE(1'b0)) u_dut32 (
        .clk(clk), .rst(rst), .in_data(d32), .in_sync(s32), .in_notify(n32),
        .out_data(od32), .out_sync(os32), .out_notify(on32));

    multi_in_accum #(.NUM_IN(4), .DATA_W(8), .SATURATE(1'b0)) u_dut_w8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_sync(s8), .in_notify(nw8),
        .out_data(odw8), .out_sync(os8), .out_notify(onw8));

    multi_in_accum #(.NUM_IN(4), .DATA_W(8), .SATURATE(1'b1)) u_dut_s8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_sync(s8), .in_notify(ns8),
        .out_data(ods8), .out_sync(os8), .out_notify(ons8));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        longint r;
        r = v & ((longint'(1) << w) - 1);
        if (r >= (longint'(1) << (w - 1))) r = r - (longint'(1) << w);
        return r;
    endfunction

    // Channel-ordered running sum with plain integer arithmetic.
    function automatic longint ref_sum(input longint q[$], input int w, input bit sat);
        longint acc;
        longint hi;
        longint lo;
        acc = 0;
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -(longint'(1) << (w - 1));
        foreach (q[i]) begin
            acc = acc + sx(q[i], w);
            if (sat) begin
                if (acc > hi) acc = hi;
                else if (acc < lo) acc = lo;
            end else begin
                acc = sx(acc, w);
            end
        end
        return acc;
    endfunction

    longint m_vals[$];
    bit     m_write = 1'b0;
    longint m_sum   = 0;

    // Drive one cycle of stimulus, then update the reference and compare at the next negedge.
    task automatic cyc32(input logic [3:0] s, input logic [127:0] d, input logic os, input string tag);
        s32  = s;
        d32  = d;
        os32 = os;
        @(posedge clk);
        @(negedge clk);
        if (!rst) begin
            m_vals.delete();
            m_write = 1'b0;
        end else if (!m_write) begin
            int p;
            p = m_vals.size();
            if (s[p]) begin
                m_vals.push_back(longint'(d[p*32 +: 32]));
                if (m_vals.size() == 4) begin
                    m_sum   = ref_sum(m_vals, 32, 1'b0);
                    m_write = 1'b1;
                end
            end
        end else if (os) begin
            m_write = 1'b0;
            m_vals.delete();
        end
        check({tag, ".in_notify"}, 64'(n32), m_write ? 64'd0 : (64'd1 << m_vals.size()));
        check({tag, ".out_notify"}, 64'(on32), 64'(m_write));
        check({tag, ".out_data"}, 64'(od32), m_write ? (m_sum & 64'hFFFF_FFFF) : 64'd0);
    endtask

    function automatic logic [127:0] rand_d32();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic round8(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                          input logic [7:0] v3, input bit use_exp, input logic [7:0] ew,
                          input logic [7:0] es, input string tag);
        longint q[$];
        bit seen;
        seen = 1'b0;
        d8   = {v3, v2, v1, v0};
        s8   = 4'hF;
        os8  = 1'b1;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (onw8) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, ".timeout"}, 64'd0, 64'd1);
        end else begin
            q = {longint'(v0), longint'(v1), longint'(v2), longint'(v3)};
            check({tag, ".sat_notify"}, 64'(ons8), 64'd1);
            if (use_exp) begin
                check({tag, ".wrap"}, 64'(odw8), 64'(ew));
                check({tag, ".sat"}, 64'(ods8), 64'(es));
            end else begin
                check({tag, ".wrap"}, 64'(odw8), ref_sum(q, 8, 1'b0) & 64'hFF);
                check({tag, ".sat"}, 64'(ods8), ref_sum(q, 8, 1'b1) & 64'hFF);
            end
        end
        s8 = 4'h0;
        @(negedge clk);
        check({tag, ".restart"}, 64'(nw8), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s32 = '0; d32 = '0; os32 = 1'b0;
        s8  = '0; d8  = '0; os8  = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check("rst.in_notify", 64'(n32), 64'd1);
        check("rst.out_notify", 64'(on32), 64'd0);
        check("rst.out_data", 64'(od32), 64'd0);
        check("rst.in_notify8", 64'(nw8), 64'd1);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) cyc32(4'h0, rand_d32(), 1'($urandom), "idle");

        for (int i = 0; i < 5; i++) begin
            cyc32(4'hF, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, "basic");
            if (i == 3) begin
                check("basic.sum", 64'(od32), 64'd10);
                check("basic.pulse", 64'(on32), 64'd1);
            end
        end

        cyc32(4'hF, rand_d32(), 1'b1, "stall");
        cyc32(4'hF, rand_d32(), 1'b1, "stall");
        for (int i = 0; i < 10; i++) cyc32(4'b1011, rand_d32(), 1'b1, "stall_in");
        cyc32(4'hF, rand_d32(), 1'b1, "stall");
        cyc32(4'hF, rand_d32(), 1'b0, "stall");
        for (int i = 0; i < 5; i++) cyc32(4'hF, rand_d32(), 1'b0, "stall_out");
        cyc32(4'h0, rand_d32(), 1'b1, "stall_done");

        for (int i = 0; i < 8; i++) cyc32(4'b1000, rand_d32(), 1'b1, "stray");

        cyc32(4'hF, rand_d32(), 1'b1, "midrst");
        cyc32(4'hF, rand_d32(), 1'b1, "midrst");
        rst = 1'b0;
        #1;
        check("midrst.in_notify", 64'(n32), 64'd1);
        check("midrst.out_notify", 64'(on32), 64'd0);
        @(negedge clk);
        m_vals.delete();
        m_write = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cyc32(4'hF, {32'd1, 32'd1, 32'd1, 32'd1}, 1'b1, "postrst");
        check("postrst.sum", 64'(od32), 64'd4);
        cyc32(4'h0, rand_d32(), 1'b1, "postrst");

        for (int i = 0; i < 400; i++) begin
            logic [127:0] d;
            d = rand_d32();
            if ($urandom_range(0, 3) == 0) d[31:0] = 32'h7FFF_FFF0;
            cyc32(4'($urandom_range(0, 15)), d, 1'($urandom_range(0, 3) != 0), "rand");
        end
        cyc32(4'h0, rand_d32(), 1'b1, "drain");

        round8(8'd127, 8'd1, 8'd0, 8'd0, 1'b1, 8'h80, 8'h7F, "pos8");
        round8(8'h80, 8'hFF, 8'd0, 8'd0, 1'b1, 8'h7F, 8'h80, "neg8");
        for (int i = 0; i < 20; i++) begin
            round8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   1'b0, 8'h00, 8'h00, "rand8");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
